// File: rtl/binom_pkg.sv
// Shared types and per-mode constants for the centered-binomial sampler.
package binom_pkg;

    localparam int K_W = 4;
    localparam int Q_W = 14;

    typedef enum logic [2:0] {
        MODE_Q3329_K2  = 3'b000,
        MODE_Q8192_K3  = 3'b001,
        MODE_Q8192_K4  = 3'b010,
        MODE_Q8192_K5  = 3'b011,
        MODE_Q12289_K8 = 3'b100
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    // Indexed directly by the 3-bit mode, so every 1xx code lands on q=12289 k=8.
    localparam logic [K_W-1:0] K_TAB [8] = '{
        4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd8, 4'd8, 4'd8
    };
    localparam logic [Q_W-1:0] Q_TAB [8] = '{
        14'd3329, 14'd8192, 14'd8192, 14'd8192,
        14'd12289, 14'd12289, 14'd12289, 14'd12289
    };

    function automatic logic [K_W-1:0] mode_k(input logic [2:0] m);
        return K_TAB[m];
    endfunction

    function automatic logic [Q_W-1:0] mode_q(input logic [2:0] m);
        return Q_TAB[m];
    endfunction

endpackage

// File: rtl/binom_lane.sv
// One combinational lane: popcount(a)-popcount(b) over a 16-bit slice.
// BINOM_SIGNED_OUT_EN selects a signed difference instead of the mod-q result.
module binom_lane
    import binom_pkg::*;
#(
    parameter int COEFF_W = 16
) (
    input  logic [15:0]        i_slice,
    input  logic [K_W-1:0]     i_k,
    input  logic [Q_W-1:0]     i_q,
    output logic [COEFF_W-1:0] o_coef
);

    logic [7:0]        w_mask;
    logic [7:0]        w_a;
    logic [7:0]        w_b;
    logic [3:0]        w_pa;
    logic [3:0]        w_pb;
    logic signed [4:0] w_diff;

    assign w_mask = 8'((9'd1 << i_k) - 9'd1);
    assign w_a    = i_slice[7:0] & w_mask;
    assign w_b    = 8'(i_slice >> i_k) & w_mask;
    assign w_pa   = 4'($countones(w_a));
    assign w_pb   = 4'($countones(w_b));
    assign w_diff = $signed({1'b0, w_pa}) - $signed({1'b0, w_pb});

`ifdef BINOM_SIGNED_OUT_EN
    logic w_unused_q;
    assign w_unused_q = ^i_q;
    assign o_coef     = {{(COEFF_W-5){w_diff[4]}}, w_diff};
`else
    logic [4:0]     w_neg;
    logic [Q_W-1:0] w_res;
    // |diff| <= 8 < q, so a single conditional add of q folds negatives into [0,q).
    assign w_neg  = 5'(-w_diff);
    assign w_res  = w_diff[4] ? (i_q - {{(Q_W-5){1'b0}}, w_neg})
                              : {{(Q_W-5){1'b0}}, w_diff};
    assign o_coef = COEFF_W'(w_res);
`endif

endmodule

// File: rtl/binom_sampler_stream.sv
// Streaming centered-binomial sampler: random words fill a bit buffer, each beat
// consumes LANES*2k bits. Optional BINOM_SIGNED_OUT_EN gives signed lane outputs.
module binom_sampler_stream
    import binom_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int LANES   = 2,
    parameter int COEFF_W = 16,
    parameter int N_COEFF = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [2:0]               mode_i,
    output logic                     busy_o,
    output logic                     done_o,
    input  logic                     rnd_valid_i,
    output logic                     rnd_ready_o,
    input  logic [IN_W-1:0]          rnd_data_i,
    output logic                     coef_valid_o,
    input  logic                     coef_ready_i,
    output logic [LANES*COEFF_W-1:0] coef_data_o,
    output logic                     coef_last_o
);

    localparam int BUF_W  = 2 * IN_W;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int NBEATS = N_COEFF / LANES;
    localparam int CNT_W  = $clog2(NBEATS + 1);

    state_e                          r_state;
    logic [2:0]                      r_mode;
    logic [BUF_W-1:0]                r_buf;
    logic [FILL_W-1:0]               r_fill;
    logic [CNT_W-1:0]                r_cnt;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_coef_valid;
    logic                            r_coef_last;
    logic [LANES-1:0][COEFF_W-1:0]   r_coef_data;

    logic [K_W-1:0]                  w_k;
    logic [Q_W-1:0]                  w_q;
    logic [31:0]                     w_need;
    logic [31:0]                     w_rem_bits;
    logic                            w_in_hs;
    logic                            w_out_hs;
    logic                            w_load;
    logic                            w_last_beat;
    logic [BUF_W-1:0]                w_merged;
    logic [BUF_W-1:0]                w_next_buf;
    logic [31:0]                     w_fill_add;
    logic [31:0]                     w_fill_sub;
    logic [FILL_W-1:0]               w_next_fill;
    logic [LANES-1:0][COEFF_W-1:0]   w_coef;

    assign w_k        = mode_k(r_mode);
    assign w_q        = mode_q(r_mode);
    assign w_need     = 32'(LANES) * 32'(w_k) * 32'd2;
    assign w_rem_bits = 32'(NBEATS - int'(r_cnt)) * w_need;

    // Input stops once the buffer already holds every bit the remaining beats need.
    assign rnd_ready_o = (r_state == ST_RUN) && (32'(r_fill) <= 32'(IN_W))
                         && (32'(r_fill) < w_rem_bits);
    assign w_in_hs     = rnd_valid_i && rnd_ready_o;
    assign w_out_hs    = r_coef_valid && coef_ready_i;
    assign w_load      = (r_state == ST_RUN) && (32'(r_fill) >= w_need)
                         && (!r_coef_valid || coef_ready_i);
    assign w_last_beat = (32'(r_cnt) == 32'(NBEATS - 1));

    assign w_merged    = r_buf | (w_in_hs ? (BUF_W'(rnd_data_i) << r_fill) : '0);
    assign w_next_buf  = w_load ? (w_merged >> w_need) : w_merged;
    assign w_fill_add  = w_in_hs ? 32'(IN_W) : 32'd0;
    assign w_fill_sub  = w_load ? w_need : 32'd0;
    assign w_next_fill = FILL_W'(32'(r_fill) + w_fill_add - w_fill_sub);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [15:0] w_slice;
        assign w_slice = 16'(r_buf >> (32'(w_k) * 32'(2 * j)));
        binom_lane #(
            .COEFF_W (COEFF_W)
        ) u_lane (
            .i_slice (w_slice),
            .i_k     (w_k),
            .i_q     (w_q),
            .o_coef  (w_coef[j])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_mode       <= '0;
            r_buf        <= '0;
            r_fill       <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_coef_valid <= 1'b0;
            r_coef_last  <= 1'b0;
            r_coef_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_RUN;
                        r_mode  <= mode_i;
                        r_buf   <= '0;
                        r_fill  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_buf  <= w_next_buf;
                    r_fill <= w_next_fill;
                    if (w_load) begin
                        r_coef_valid <= 1'b1;
                        r_coef_data  <= w_coef;
                        r_coef_last  <= w_last_beat;
                        r_cnt        <= r_cnt + 1'b1;
                        if (w_last_beat) r_state <= ST_DRAIN;
                    end else if (w_out_hs) begin
                        r_coef_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Leftover buffer bits are dropped when the final beat leaves.
                    if (w_out_hs) begin
                        r_state      <= ST_IDLE;
                        r_coef_valid <= 1'b0;
                        r_coef_last  <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_buf        <= '0;
                        r_fill       <= '0;
                        r_cnt        <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign coef_valid_o = r_coef_valid;
    assign coef_last_o  = r_coef_last;
    assign coef_data_o  = r_coef_data;

endmodule

// File: tb/tb_binom_sampler_stream.sv
// Scoreboard bench: stimulus pushes expected beats, a monitor pops and compares.
module tb_binom_sampler_stream;
    localparam int IN_W = 32, LANES = 2, COEFF_W = 16, N_COEFF = 256;
    localparam int NBEATS = N_COEFF / LANES;
    localparam int DW = LANES * COEFF_W;

    logic clk_i = 1'b0, rst_ni = 1'b1, start_i = 1'b0;
    logic [2:0] mode_i = '0;
    logic busy_o, done_o, rnd_ready_o, coef_valid_o, coef_last_o;
    logic rnd_valid_i = 1'b0, coef_ready_i = 1'b1;
    logic [IN_W-1:0] rnd_data_i = '0;
    logic [DW-1:0] coef_data_o;

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    beat_t exp_q[$];
    logic [IN_W-1:0] word_q[$];
    logic [IN_W-1:0] jw[$];
    bit mbits[$];
    int total = 0, bad = 0, cyc = 0, beats_seen = 0, done_cnt = 0, acc_words = 0, gen_beats = 0;
    int m_k = 2, m_q = 3329, bp_from = 0, first_hs = 0, last_hs = 0;
    bit use_model = 0, gap_en = 0, rr_en = 0, bp_en = 0, saw_drop = 0;

    always #5 clk_i = ~clk_i;

    binom_sampler_stream #(.IN_W(IN_W), .LANES(LANES), .COEFF_W(COEFF_W), .N_COEFF(N_COEFF)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
        .busy_o(busy_o), .done_o(done_o),
        .rnd_valid_i(rnd_valid_i), .rnd_ready_o(rnd_ready_o), .rnd_data_i(rnd_data_i),
        .coef_valid_o(coef_valid_o), .coef_ready_i(coef_ready_i),
        .coef_data_o(coef_data_o), .coef_last_o(coef_last_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic int tb_k(input logic [2:0] m);
        if (m[2]) return 8;
        return 2 + int'(m[1:0]);
    endfunction

    function automatic int tb_q(input logic [2:0] m);
        if (m[2]) return 12289;
        return (m[1:0] == 2'b00) ? 3329 : 8192;
    endfunction

    // Golden model: a plain LSB-first bit stream cut into beats of LANES*2k bits.
    task automatic model_word(input logic [IN_W-1:0] w);
        for (int i = 0; i < IN_W; i++) mbits.push_back(w[i]);
        while (gen_beats < NBEATS && mbits.size() >= LANES * 2 * m_k) begin
            beat_t b;
            b.data = '0;
            for (int j = 0; j < LANES; j++) begin
                int pa, pb, d;
                logic [COEFF_W-1:0] v;
                pa = 0; pb = 0;
                for (int i = 0; i < m_k; i++) begin
                    pa += int'(mbits[2*m_k*j + i]);
                    pb += int'(mbits[2*m_k*j + m_k + i]);
                end
                d = pa - pb;
`ifdef BINOM_SIGNED_OUT_EN
                v = COEFF_W'(d);
`else
                v = COEFF_W'((d < 0) ? d + m_q : d);
`endif
                b.data[j*COEFF_W +: COEFF_W] = v;
            end
            gen_beats++;
            b.last = (gen_beats == NBEATS);
            exp_q.push_back(b);
            repeat (LANES * 2 * m_k) void'(mbits.pop_front());
        end
    endtask

    // Random-word source.
    initial begin
        forever begin
            @(negedge clk_i);
            if (word_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
                rnd_valid_i = 1'b1;
                rnd_data_i  = word_q[0];
            end else begin
                rnd_valid_i = 1'b0;
                rnd_data_i  = '0;
            end
            #4;
            if (rst_ni && rnd_valid_i && rnd_ready_o) begin
                void'(word_q.pop_front());
                acc_words++;
                if (use_model) model_word(rnd_data_i);
            end
        end
    end

    // Output-side ready control.
    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            if (bp_en)      coef_ready_i = !(cyc >= bp_from && cyc < bp_from + 5);
            else if (rr_en) coef_ready_i = ($urandom_range(0, 2) != 0);
            else            coef_ready_i = 1'b1;
        end
    end

    // Monitor: samples 1ns before each rising edge.
    initial begin
        bit hold, pbusy;
        logic [DW-1:0] hd;
        logic hl;
        beat_t e;
        hold = 0; pbusy = 0; hd = '0; hl = 1'b0;
        forever begin
            @(negedge clk_i);
            #4;
            if (!rst_ni) begin
                hold = 0; pbusy = 0;
            end else begin
                if (hold) begin
                    chk("hold_valid", coef_valid_o, 1);
                    chk("hold_data", coef_data_o, hd);
                    chk("hold_last", coef_last_o, hl);
                end
                if (coef_valid_o && coef_ready_i) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_beat: got %0h expected no beat", coef_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", coef_data_o, e.data);
                        chk("beat_last", coef_last_o, e.last);
                    end
                    beats_seen++;
                    if (beats_seen == 1) first_hs = cyc;
                    last_hs = cyc;
                end
                if (bp_en && !coef_ready_i && busy_o && !rnd_ready_o) saw_drop = 1;
                if (done_o) begin
                    done_cnt++;
                    chk("busy_low_with_done", busy_o, 0);
                    chk("busy_high_before_done", pbusy, 1);
                end
                hold  = coef_valid_o && !coef_ready_i;
                hd    = coef_data_o;
                hl    = coef_last_o;
                pbusy = busy_o;
            end
        end
    end

    task automatic start_job(input logic [2:0] m);
        @(negedge clk_i); #1;
        mode_i = m; start_i = 1'b1;
        @(negedge clk_i); #1;
        start_i = 1'b0; mode_i = ~m;
    endtask

    task automatic finish_job(input string name, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin @(negedge clk_i); n++; end
        if (done_cnt == d0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no done_o expected done within 3000 cycles", name);
        end
        repeat (3) @(negedge clk_i);
        chk({name, "_done_once"}, done_cnt - d0, 1);
        chk({name, "_exp_empty"}, exp_q.size(), 0);
        chk({name, "_idle_busy"}, busy_o, 0);
    endtask

    task automatic directed(input string name, input logic [2:0] m, input int nwords,
                            input logic [IN_W-1:0] w0, input logic [DW-1:0] b0);
        int d0;
        beat_t b;
        use_model = 0;
        for (int i = 0; i < NBEATS; i++) begin
            b.data = (i == 0) ? b0 : '0;
            b.last = (i == NBEATS - 1);
            exp_q.push_back(b);
        end
        word_q.push_back(w0);
        for (int i = 1; i < nwords; i++) word_q.push_back('0);
        d0 = done_cnt; beats_seen = 0; acc_words = 0;
        start_job(m);
        finish_job(name, d0);
        chk({name, "_words"}, acc_words, nwords);
        word_q.delete();
    endtask

    task automatic model_setup(input logic [2:0] m);
        m_k = tb_k(m); m_q = tb_q(m);
        mbits.delete(); exp_q.delete(); gen_beats = 0; use_model = 1;
    endtask

    task automatic rand_job(input string name, input logic [2:0] m, input int extra);
        int d0;
        model_setup(m);
        foreach (jw[i]) word_q.push_back(jw[i]);
        for (int i = 0; i < extra; i++) word_q.push_back($urandom);
        d0 = done_cnt; beats_seen = 0; acc_words = 0;
        start_job(m);
        finish_job(name, d0);
        chk({name, "_words"}, acc_words, jw.size());
        chk({name, "_beats"}, beats_seen, NBEATS);
        word_q.delete(); use_model = 0;
    endtask

    task automatic fill_jw(input int n);
        jw.delete();
        for (int i = 0; i < n; i++) jw.push_back($urandom);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"}, busy_o, 0);
        chk({name, "_done"}, done_o, 0);
        chk({name, "_rnd_ready"}, rnd_ready_o, 0);
        chk({name, "_coef_valid"}, coef_valid_o, 0);
        chk({name, "_coef_last"}, coef_last_o, 0);
        chk({name, "_coef_data"}, coef_data_o, 0);
    endtask

    initial begin
        int d0, n;
        #1 rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_reset_outputs("por");
        #1 rst_ni = 1'b1;

`ifdef BINOM_SIGNED_OUT_EN
        directed("dir_a2", 3'b000, 32, 32'h0000_0003, {16'd0, 16'd2});
        directed("dir_b2", 3'b000, 32, 32'h0000_000C, {16'd0, 16'hFFFE});
        directed("dir_k8", 3'b100, 128, 32'h0000_FF00, {16'd0, 16'hFFF8});
`else
        directed("dir_a2", 3'b000, 32, 32'h0000_0003, {16'd0, 16'd2});
        directed("dir_b2", 3'b000, 32, 32'h0000_000C, {16'd0, 16'd3327});
        directed("dir_k8", 3'b100, 128, 32'h0000_FF00, {16'd0, 16'd12281});
`endif

        // Full mode-000 job, input always valid, 8 surplus words offered.
        fill_jw(32);
        rand_job("full", 3'b000, 8);
        chk("full_throughput", last_hs - first_hs, NBEATS - 1);

        // Back-pressure window plus a stray start pulse mid-job.
        fill_jw(48);
        bp_from = cyc + 30; bp_en = 1; saw_drop = 0;
        fork
            rand_job("bp", 3'b001, 4);
            begin
                repeat (12) @(negedge clk_i);
                #1 start_i = 1'b1; mode_i = 3'b100;
                @(negedge clk_i);
                #1 start_i = 1'b0;
            end
        join
        bp_en = 0;
        chk("bp_rnd_ready_drop", saw_drop, 1);

        fill_jw(64); gap_en = 1;
        rand_job("gaps_k4", 3'b010, 0);
        gap_en = 0;
        fill_jw(80); rr_en = 1;
        rand_job("rready_k5", 3'b011, 0);
        rr_en = 0;
        fill_jw(128);
        rand_job("k8_mode111", 3'b111, 2);

        // Abort at beat 40, then rerun the same words from a clean start.
        fill_jw(32);
        model_setup(3'b000);
        foreach (jw[i]) word_q.push_back(jw[i]);
        d0 = done_cnt; beats_seen = 0; acc_words = 0;
        start_job(3'b000);
        n = 0;
        while (beats_seen < 40 && n < 500) begin @(negedge clk_i); n++; end
        if (beats_seen < 40) begin
            total++; bad++;
            $display("FAIL abort_wait: got %0d beats expected 40", beats_seen);
        end
        #1 rst_ni = 1'b0;
        use_model = 0; word_q.delete(); exp_q.delete(); mbits.delete(); gen_beats = 0;
        #1 chk_reset_outputs("abort");
        repeat (3) @(negedge clk_i);
        chk("abort_no_done", done_cnt - d0, 0);
        #1 rst_ni = 1'b1;
        rand_job("rerun", 3'b000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
